// File: rtl/rc2014_mem_cycle_ctrl.sv
// rc2014_mem_cycle_ctrl
// Runs Z80 memory cycles from the RC2014 backplane against FPGA block memory.
// Two address windows are decoded: a ROM window and a RAM window. The bus
// strobes are synchronised into fpga_clk, the block-RAM access is issued, and
// the data transceiver direction and output enable are controlled for the
// rest of the cycle.
//
// Ports
//   fpga_clk, rst_n           clock, async active-low reset
//   bus_a, bus_d_in           Z80 address / write data (sampled in DECODE only)
//   bus_mreq_n/rd_n/wr_n      raw asynchronous bus strobes
//   bus_d_out, data_oe,       read data, transceiver enable and direction
//   data_dir                  (1 = FPGA drives the bus)
//   wait_n                    Z80 WAIT, held low while read data is fetched
//   mem_ce/we/sel/addr/wdata  single-cycle block-RAM access (sel 0 ROM, 1 RAM)
//   mem_rdata                 read data from the selected memory
//   rom_wr_err                sticky flag: a write hit the ROM window
//   access_cnt                completed in-window cycles, wraps at 8 bits
module rc2014_mem_cycle_ctrl #(
    parameter logic [15:0] ROM_BASE    = 16'h0000,
    parameter logic [15:0] RAM_BASE    = 16'h8000,
    parameter int unsigned WIN_AW      = 13,
    parameter int unsigned MEM_LATENCY = 1,
    parameter int unsigned SYNC_STAGES = 2,
    parameter bit          WAIT_EN     = 1'b1
) (
    input  logic              fpga_clk,
    input  logic              rst_n,
    input  logic [15:0]       bus_a,
    input  logic [7:0]        bus_d_in,
    input  logic              bus_mreq_n,
    input  logic              bus_rd_n,
    input  logic              bus_wr_n,
    output logic [7:0]        bus_d_out,
    output logic              data_oe,
    output logic              data_dir,
    output logic              wait_n,
    output logic              mem_ce,
    output logic              mem_we,
    output logic              mem_sel,
    output logic [WIN_AW-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    output logic              rom_wr_err,
    output logic [7:0]        access_cnt
);

    localparam int unsigned TAG_W = 16 - WIN_AW;
    localparam logic [TAG_W-1:0] ROM_TAG = ROM_BASE[15:WIN_AW];
    localparam logic [TAG_W-1:0] RAM_TAG = RAM_BASE[15:WIN_AW];
    localparam logic [1:0] LAT_LAST = 2'(MEM_LATENCY - 1);

    typedef enum logic [2:0] {
        StIdle,
        StDecode,
        StRdWait,
        StRdDrive,
        StWrIssue,
        StHold
    } state_e;

    // Strobe synchronisers; reset to 1 so the strobes read as inactive.
    logic [SYNC_STAGES-1:0] r_mreq_sync;
    logic [SYNC_STAGES-1:0] r_rd_sync;
    logic [SYNC_STAGES-1:0] r_wr_sync;

    always_ff @(posedge fpga_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mreq_sync <= '1;
            r_rd_sync   <= '1;
            r_wr_sync   <= '1;
        end else begin
            r_mreq_sync <= {r_mreq_sync[SYNC_STAGES-2:0], bus_mreq_n};
            r_rd_sync   <= {r_rd_sync[SYNC_STAGES-2:0], bus_rd_n};
            r_wr_sync   <= {r_wr_sync[SYNC_STAGES-2:0], bus_wr_n};
        end
    end

    logic w_mreq_s, w_rd_s, w_wr_s;
    logic w_start, w_release, w_bus_idle;

    assign w_mreq_s   = r_mreq_sync[SYNC_STAGES-1];
    assign w_rd_s     = r_rd_sync[SYNC_STAGES-1];
    assign w_wr_s     = r_wr_sync[SYNC_STAGES-1];
    assign w_start    = !w_mreq_s && (!w_rd_s || !w_wr_s);
    assign w_release  = w_mreq_s || (w_rd_s && w_wr_s);
    assign w_bus_idle = w_mreq_s && w_rd_s && w_wr_s;

    // Window decode; ROM wins when the windows overlap.
    logic w_rom_hit, w_ram_hit;
    assign w_rom_hit = (bus_a[15:WIN_AW] == ROM_TAG);
    assign w_ram_hit = !w_rom_hit && (bus_a[15:WIN_AW] == RAM_TAG);

    state_e            r_state, w_state_d;
    logic [WIN_AW-1:0] r_addr, w_addr_d;
    logic              r_sel, w_sel_d;
    logic [7:0]        r_wdata, w_wdata_d;
    logic [7:0]        r_dout, w_dout_d;
    logic              r_drive, w_drive_d;
    logic              r_abort, w_abort_d;
    logic [1:0]        r_lat_cnt, w_lat_d;
    logic              r_rom_err, w_err_d;
    logic [7:0]        r_cnt, w_cnt_d;
    logic              w_wait_req;

    always_ff @(posedge fpga_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= StIdle;
            r_addr    <= '0;
            r_sel     <= 1'b0;
            r_wdata   <= 8'h00;
            r_dout    <= 8'h00;
            r_drive   <= 1'b0;
            r_abort   <= 1'b0;
            r_lat_cnt <= 2'd0;
            r_rom_err <= 1'b0;
            r_cnt     <= 8'h00;
        end else begin
            r_state   <= w_state_d;
            r_addr    <= w_addr_d;
            r_sel     <= w_sel_d;
            r_wdata   <= w_wdata_d;
            r_dout    <= w_dout_d;
            r_drive   <= w_drive_d;
            r_abort   <= w_abort_d;
            r_lat_cnt <= w_lat_d;
            r_rom_err <= w_err_d;
            r_cnt     <= w_cnt_d;
        end
    end

    always_comb begin
        w_state_d  = r_state;
        w_addr_d   = r_addr;
        w_sel_d    = r_sel;
        w_wdata_d  = r_wdata;
        w_dout_d   = r_dout;
        w_drive_d  = r_drive;
        w_abort_d  = r_abort;
        w_lat_d    = r_lat_cnt;
        w_err_d    = r_rom_err;
        w_cnt_d    = r_cnt;
        w_wait_req = 1'b0;
        mem_ce     = 1'b0;
        mem_we     = 1'b0;
        mem_sel    = r_sel;
        mem_addr   = r_addr;

        unique case (r_state)
            StIdle: begin
                if (w_start) begin
                    w_state_d = StDecode;
                end
            end
            StDecode: begin
                w_addr_d  = bus_a[WIN_AW-1:0];
                w_wdata_d = bus_d_in;
                w_sel_d   = !w_rom_hit;
                w_abort_d = 1'b0;
                w_lat_d   = 2'd0;
                // Read access goes out straight from the live address.
                mem_addr  = bus_a[WIN_AW-1:0];
                mem_sel   = !w_rom_hit;
                if (w_rom_hit || w_ram_hit) begin
                    if (!w_rd_s) begin
                        // rd low wins even if wr is also low
                        mem_ce     = 1'b1;
                        w_wait_req = 1'b1;
                        w_state_d  = StRdWait;
                    end else if (w_rom_hit) begin
                        w_err_d   = 1'b1;
                        w_state_d = StHold;
                    end else begin
                        w_state_d = StWrIssue;
                    end
                end else begin
                    w_state_d = StHold;
                end
            end
            StRdWait: begin
                w_wait_req = 1'b1;
                w_abort_d  = r_abort || w_release;
                if (r_lat_cnt == LAT_LAST) begin
                    // Memory pipeline is drained either way; only drive if
                    // the strobes are still asserted.
                    if (r_abort || w_release) begin
                        w_state_d = StIdle;
                    end else begin
                        w_dout_d  = mem_rdata;
                        w_drive_d = 1'b1;
                        w_cnt_d   = r_cnt + 8'd1;
                        w_state_d = StRdDrive;
                    end
                end else begin
                    w_lat_d = r_lat_cnt + 2'd1;
                end
            end
            StRdDrive: begin
                w_state_d = StHold;
            end
            StWrIssue: begin
                mem_ce    = 1'b1;
                mem_we    = 1'b1;
                w_cnt_d   = r_cnt + 8'd1;
                w_state_d = StHold;
            end
            StHold: begin
                if (w_bus_idle) begin
                    w_drive_d = 1'b0;
                    w_state_d = StIdle;
                end
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    // WAIT releases as soon as a synced strobe release is seen.
    assign wait_n     = !(WAIT_EN && w_wait_req && !r_abort && !w_release);
    // Raw strobes gate the driver so it lets go the moment rd_n/mreq_n rise.
    assign data_oe    = r_drive && !bus_rd_n && !bus_mreq_n;
    assign data_dir   = r_drive;
    assign bus_d_out  = r_dout;
    assign mem_wdata  = r_wdata;
    assign rom_wr_err = r_rom_err;
    assign access_cnt = r_cnt;

endmodule

// File: tb/tb_rc2014_mem_cycle_ctrl.sv
// Bench for rc2014_mem_cycle_ctrl. Two instances share the bus: u_dut with
// default parameters (MEM_LATENCY=1) and u_dut3 with MEM_LATENCY=3.
// Expected memory accesses and read-drive data for u_dut are queued by the
// stimulus and consumed by a negedge monitor.
module tb_rc2014_mem_cycle_ctrl;

    logic        clk;
    logic        rst_n;
    logic [15:0] bus_a;
    logic [7:0]  bus_d_in;
    logic        bus_mreq_n, bus_rd_n, bus_wr_n;
    logic [7:0]  mem_rdata;

    logic [7:0]  bus_d_out, bus_d_out3;
    logic        data_oe, data_oe3, data_dir, data_dir3, wait_n, wait_n3;
    logic        mem_ce, mem_ce3, mem_we, mem_we3, mem_sel, mem_sel3;
    logic [12:0] mem_addr, mem_addr3;
    logic [7:0]  mem_wdata, mem_wdata3;
    logic        rom_wr_err, rom_wr_err3;
    logic [7:0]  access_cnt, access_cnt3;

    rc2014_mem_cycle_ctrl u_dut (
        .fpga_clk(clk), .rst_n(rst_n), .bus_a(bus_a), .bus_d_in(bus_d_in),
        .bus_mreq_n(bus_mreq_n), .bus_rd_n(bus_rd_n), .bus_wr_n(bus_wr_n),
        .bus_d_out(bus_d_out), .data_oe(data_oe), .data_dir(data_dir),
        .wait_n(wait_n), .mem_ce(mem_ce), .mem_we(mem_we), .mem_sel(mem_sel),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .rom_wr_err(rom_wr_err), .access_cnt(access_cnt)
    );

    rc2014_mem_cycle_ctrl #(.MEM_LATENCY(3)) u_dut3 (
        .fpga_clk(clk), .rst_n(rst_n), .bus_a(bus_a), .bus_d_in(bus_d_in),
        .bus_mreq_n(bus_mreq_n), .bus_rd_n(bus_rd_n), .bus_wr_n(bus_wr_n),
        .bus_d_out(bus_d_out3), .data_oe(data_oe3), .data_dir(data_dir3),
        .wait_n(wait_n3), .mem_ce(mem_ce3), .mem_we(mem_we3), .mem_sel(mem_sel3),
        .mem_addr(mem_addr3), .mem_wdata(mem_wdata3), .mem_rdata(mem_rdata),
        .rom_wr_err(rom_wr_err3), .access_cnt(access_cnt3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic        sel;
        logic [12:0] addr;
        logic [7:0]  wdata;
    } mem_exp_t;

    mem_exp_t   mem_q[$];
    logic [7:0] drv_q[$];

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int wlow1, wlow3, oe3_hi;
    logic prev_oe = 1'b0;
    mem_exp_t me;
    logic [7:0] de;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Posedges since mreq_n fell; edge 1 is the first edge that samples it.
    always @(posedge clk) begin
        if (bus_mreq_n) cyc <= 0;
        else            cyc <= cyc + 1;
    end

    // Scoreboard monitor for u_dut.
    always @(negedge clk) begin
        if (mem_ce === 1'b1) begin
            if (mem_q.size() == 0) begin
                chk("unexpected mem_ce", 1, 0);
            end else begin
                me = mem_q.pop_front();
                chk("mem_we", mem_we, me.we);
                chk("mem_sel", mem_sel, me.sel);
                chk("mem_addr", mem_addr, me.addr);
                if (me.we) chk("mem_wdata", mem_wdata, me.wdata);
            end
        end
        if (data_oe === 1'b1 && !prev_oe) begin
            if (drv_q.size() == 0) begin
                chk("unexpected data_oe", 1, 0);
            end else begin
                de = drv_q.pop_front();
                chk("bus_d_out", bus_d_out, de);
                // SYNC_STAGES + 1 + MEM_LATENCY = 4 cycles after first sample
                chk("drive_latency", cyc - 1, 4);
            end
        end
        prev_oe = data_oe;
    end

    task automatic sample();
        if (!wait_n)  wlow1++;
        if (!wait_n3) wlow3++;
        if (data_oe3) oe3_hi++;
    endtask

    // Entered just after a posedge. Holds the strobes for 'hold' cycles.
    task automatic bus_cycle(input logic [15:0] a, input logic is_wr, input logic [7:0] wd,
                             input logic [7:0] rdata, input int hold, input logic exp_drv);
        wlow1 = 0; wlow3 = 0; oe3_hi = 0;
        mem_rdata  = rdata;
        bus_a      = a;
        bus_d_in   = wd;
        bus_mreq_n = 1'b0;
        if (is_wr) bus_wr_n = 1'b0;
        else       bus_rd_n = 1'b0;
        repeat (hold) begin @(negedge clk); sample(); end
        @(posedge clk); #1;
        chk("data_oe before release", data_oe, exp_drv);
        bus_mreq_n = 1'b1;
        bus_rd_n   = 1'b1;
        bus_wr_n   = 1'b1;
        #1;
        chk("data_oe on release", data_oe, 0);
        chk("data_oe3 on release", data_oe3, 0);
        repeat (7) begin @(negedge clk); sample(); end
        @(posedge clk); #1;
    endtask

    initial begin
        rst_n = 1'b0;
        bus_a = 16'h0000; bus_d_in = 8'h00; mem_rdata = 8'h00;
        bus_mreq_n = 1'b1; bus_rd_n = 1'b1; bus_wr_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset wait_n", wait_n, 1);
        chk("reset data_oe", data_oe, 0);
        chk("reset data_dir", data_dir, 0);
        chk("reset mem_ce", mem_ce, 0);
        chk("reset bus_d_out", bus_d_out, 8'h00);
        chk("reset access_cnt", access_cnt, 0);
        chk("reset rom_wr_err", rom_wr_err, 0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // ROM read hit
        mem_q.push_back('{we: 1'b0, sel: 1'b0, addr: 13'h0123, wdata: 8'h00});
        drv_q.push_back(8'hA5);
        bus_cycle(16'h0123, 1'b0, 8'h00, 8'hA5, 8, 1'b1);
        chk("read cnt", access_cnt, 1);
        chk("read cnt3", access_cnt3, 1);
        chk("read wait low cycles", wlow1, 2);
        chk("read wait low cycles lat3", wlow3, 4);
        chk("read lat3 dout", bus_d_out3, 8'hA5);
        chk("read lat3 drove", oe3_hi > 0, 1);
        chk("data_dir back in idle", data_dir, 0);

        // RAM write
        mem_q.push_back('{we: 1'b1, sel: 1'b1, addr: 13'h0010, wdata: 8'h5A});
        bus_cycle(16'h8010, 1'b1, 8'h5A, 8'h00, 8, 1'b0);
        chk("write cnt", access_cnt, 2);
        chk("write cnt3", access_cnt3, 2);
        chk("write no drive lat3", oe3_hi, 0);
        chk("write wait high", wlow1, 0);

        // ROM write: flagged, no access
        bus_cycle(16'h0004, 1'b1, 8'h33, 8'h00, 8, 1'b0);
        chk("rom_wr_err", rom_wr_err, 1);
        chk("rom_wr_err3", rom_wr_err3, 1);
        chk("rom write cnt", access_cnt, 2);

        // Miss
        bus_cycle(16'h4000, 1'b0, 8'h00, 8'hEE, 8, 1'b0);
        chk("miss wait high", wlow1, 0);
        chk("miss wait high lat3", wlow3, 0);
        chk("miss cnt", access_cnt, 2);
        chk("miss no drive lat3", oe3_hi, 0);

        // Aborted read: rd_n released before the drive phase
        mem_q.push_back('{we: 1'b0, sel: 1'b0, addr: 13'h0200, wdata: 8'h00});
        bus_cycle(16'h0200, 1'b0, 8'h00, 8'h3C, 2, 1'b0);
        chk("abort cnt", access_cnt, 2);
        chk("abort cnt3", access_cnt3, 2);
        chk("abort no drive lat3", oe3_hi, 0);
        chk("abort dout kept", bus_d_out, 8'hA5);
        chk("abort dout3 kept", bus_d_out3, 8'hA5);
        chk("abort wait low cycles", wlow1, 1);
        chk("abort wait low cycles lat3", wlow3, 1);
        chk("rom_wr_err sticky", rom_wr_err, 1);

        // Reset while u_dut is in RD_DRIVE (u_dut3 still waiting)
        mem_q.push_back('{we: 1'b0, sel: 1'b1, addr: 13'h0001, wdata: 8'h00});
        mem_rdata  = 8'h77;
        bus_a      = 16'h8001;
        bus_mreq_n = 1'b0;
        bus_rd_n   = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("pre-reset data_oe", data_oe, 1);
        chk("pre-reset cnt", access_cnt, 3);
        chk("pre-reset wait_n3", wait_n3, 0);
        rst_n = 1'b0;
        #1;
        chk("mid reset data_oe", data_oe, 0);
        chk("mid reset data_dir", data_dir, 0);
        chk("mid reset wait_n3", wait_n3, 1);
        chk("mid reset mem_ce3", mem_ce3, 0);
        chk("mid reset cnt", access_cnt, 0);
        chk("mid reset rom_wr_err", rom_wr_err, 0);
        @(posedge clk); #1;
        bus_mreq_n = 1'b1;
        bus_rd_n   = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // 256 RAM reads: counter wraps to 0
        for (int i = 0; i < 256; i++) begin
            logic [7:0] rd;
            rd = 8'(i) ^ 8'h5A;
            mem_q.push_back('{we: 1'b0, sel: 1'b1, addr: 13'(i), wdata: 8'h00});
            drv_q.push_back(rd);
            bus_cycle(16'h8000 | 16'(i), 1'b0, 8'h00, rd, 8, 1'b1);
            if (i == 254) chk("cnt before wrap", access_cnt, 255);
        end
        chk("cnt wrapped", access_cnt, 0);
        chk("cnt3 wrapped", access_cnt3, 0);
        chk("rom_wr_err after reset", rom_wr_err, 0);
        chk("mem queue drained", mem_q.size(), 0);
        chk("drive queue drained", drv_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
